// File: rtl/gpio_in_conditioner_if.sv
// gpio_in_conditioner_if: pad inputs, controls and conditioned outputs of one GPIO input port.
interface gpio_in_conditioner_if #(parameter int GPIO_WIDTH = 8);
  logic [GPIO_WIDTH-1:0] pad_in;
  logic                  bypass;
  logic [GPIO_WIDTH-1:0] evt_clr;
  logic [GPIO_WIDTH-1:0] gpio_clean;
  logic [GPIO_WIDTH-1:0] rise_evt;
  logic [GPIO_WIDTH-1:0] fall_evt;
  logic                  irq;
  modport master (output pad_in, bypass, evt_clr, input gpio_clean, rise_evt, fall_evt, irq);
  modport slave  (input pad_in, bypass, evt_clr, output gpio_clean, rise_evt, fall_evt, irq);
endinterface

// File: rtl/gpio_in_conditioner.sv
// gpio_in_conditioner: two-flop synchronizer, per-bit debounce and sticky edge events with level irq.
module gpio_in_conditioner #(
  parameter int GPIO_WIDTH      = 8,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input logic clk,
  input logic rst,
  gpio_in_conditioner_if.slave io
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [GPIO_WIDTH-1:0] sync1_q, sync2_q, clean_q, clean_d, rise_q, rise_d, fall_q, fall_d;
  logic [CW-1:0] cnt_q [GPIO_WIDTH];
  logic [CW-1:0] cnt_d [GPIO_WIDTH];
  logic [GPIO_WIDTH-1:0] upd;
  always_comb begin
    clean_d = clean_q;
    rise_d  = rise_q;
    fall_d  = fall_q;
    cnt_d   = cnt_q;
    upd     = '0;
    for (int i = 0; i < GPIO_WIDTH; i++) begin
      upd[i]   = (sync2_q[i] != clean_q[i]) && (io.bypass || cnt_q[i] == CNT_LAST);
      cnt_d[i] = (io.bypass || sync2_q[i] == clean_q[i] || upd[i]) ? '0 : cnt_q[i] + CW'(1);
      clean_d[i] = upd[i] ? sync2_q[i] : clean_q[i];
      // a new event in the same cycle as its clear takes priority
      rise_d[i] = (upd[i] && sync2_q[i]) || (rise_q[i] && !io.evt_clr[i]);
      fall_d[i] = (upd[i] && !sync2_q[i]) || (fall_q[i] && !io.evt_clr[i]);
    end
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      sync1_q <= '0;
      sync2_q <= '0;
      clean_q <= '0;
      rise_q  <= '0;
      fall_q  <= '0;
      cnt_q   <= '{default: '0};
    end else begin
      sync1_q <= io.pad_in;
      sync2_q <= sync1_q;
      clean_q <= clean_d;
      rise_q  <= rise_d;
      fall_q  <= fall_d;
      cnt_q   <= cnt_d;
    end
  end
  assign io.gpio_clean = clean_q;
  assign io.rise_evt   = rise_q;
  assign io.fall_evt   = fall_q;
  assign io.irq        = |{rise_q, fall_q};
endmodule

// File: tb/tb_gpio_in_conditioner.sv
// tb_gpio_in_conditioner: directed scenario tasks with hand-computed expectations (D=4).
module tb_gpio_in_conditioner;
  logic clk = 1'b0;
  logic rst;
  int tests = 0;
  int fails = 0;
  always #5 clk = ~clk;
  gpio_in_conditioner_if #(.GPIO_WIDTH(8)) io();
  gpio_in_conditioner #(.GPIO_WIDTH(8), .DEBOUNCE_CYCLES(4)) dut (.clk(clk), .rst(rst), .io(io));

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    io.pad_in = 8'h00;
    io.bypass = 1'b0;
    io.evt_clr = 8'h00;
    tick();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests++;
    if ({io.gpio_clean, io.rise_evt, io.fall_evt, io.irq} !== 25'h0) begin
      fails++;
      $display("FAIL reset: got clean=%h rise=%h fall=%h irq=%b, want all 0", io.gpio_clean, io.rise_evt, io.fall_evt, io.irq);
    end
  endtask

  task automatic test_rise_latency();
    logic exp_on;
    do_reset();
    io.pad_in = 8'h01;
    for (int e = 1; e <= 6; e++) begin
      tick();
      exp_on = (e >= 6);
      tests++;
      if (io.gpio_clean !== {7'h0, exp_on} || io.rise_evt !== {7'h0, exp_on} || io.irq !== exp_on || io.fall_evt !== 8'h00) begin
        fails++;
        $display("FAIL rise_latency edge %0d: got clean=%h rise=%h fall=%h irq=%b, want clean=rise=%h irq=%b",
                 e, io.gpio_clean, io.rise_evt, io.fall_evt, io.irq, {7'h0, exp_on}, exp_on);
      end
    end
  endtask

  task automatic test_glitch();
    do_reset();
    io.pad_in = 8'h08;
    for (int e = 1; e <= 12; e++) begin
      tick();
      if (e == 3) io.pad_in = 8'h00;
      tests++;
      if (io.gpio_clean !== 8'h00 || io.rise_evt !== 8'h00 || io.fall_evt !== 8'h00) begin
        fails++;
        $display("FAIL glitch edge %0d: got clean=%h rise=%h fall=%h, want 00", e, io.gpio_clean, io.rise_evt, io.fall_evt);
      end
    end
  endtask

  task automatic test_fall_and_clear();
    do_reset();
    io.pad_in = 8'hFF;
    repeat (6) tick();
    io.evt_clr = 8'hFF;
    tick();
    io.evt_clr = 8'h00;
    tests++;
    if (io.gpio_clean !== 8'hFF || io.rise_evt !== 8'h00 || io.irq !== 1'b0) begin
      fails++;
      $display("FAIL fall_setup: got clean=%h rise=%h irq=%b, want FF 00 0", io.gpio_clean, io.rise_evt, io.irq);
    end
    io.pad_in = 8'h0F;
    repeat (5) tick();
    tests++;
    if (io.gpio_clean !== 8'hFF || io.fall_evt !== 8'h00) begin
      fails++;
      $display("FAIL fall_early: got clean=%h fall=%h, want FF 00", io.gpio_clean, io.fall_evt);
    end
    tick();
    tests++;
    if (io.gpio_clean !== 8'h0F || io.fall_evt !== 8'hF0 || io.rise_evt !== 8'h00 || io.irq !== 1'b1) begin
      fails++;
      $display("FAIL fall_update: got clean=%h fall=%h rise=%h irq=%b, want 0F F0 00 1", io.gpio_clean, io.fall_evt, io.rise_evt, io.irq);
    end
    io.evt_clr = 8'hF0;
    tick();
    io.evt_clr = 8'h00;
    tests++;
    if (io.fall_evt !== 8'h00 || io.rise_evt !== 8'h00 || io.irq !== 1'b0) begin
      fails++;
      $display("FAIL evt_clear: got fall=%h rise=%h irq=%b, want 00 00 0", io.fall_evt, io.rise_evt, io.irq);
    end
    repeat (3) tick();
    tests++;
    if (io.fall_evt !== 8'h00 || io.gpio_clean !== 8'h0F) begin
      fails++;
      $display("FAIL evt_stays_clear: got fall=%h clean=%h, want 00 0F", io.fall_evt, io.gpio_clean);
    end
  endtask

  task automatic test_bypass();
    logic [2:0] hist = 3'b000;
    do_reset();
    io.bypass = 1'b1;
    for (int n = 0; n < 16; n++) begin
      io.pad_in[7] = ((n / 4) % 2 == 0);
      tick();
      hist = {hist[1:0], io.pad_in[7]};
      tests++;
      if (io.gpio_clean[7] !== hist[2]) begin
        fails++;
        $display("FAIL bypass edge %0d: got clean[7]=%b, want %b", n, io.gpio_clean[7], hist[2]);
      end
    end
    tests++;
    if (io.rise_evt !== 8'h80 || io.fall_evt !== 8'h80) begin
      fails++;
      $display("FAIL bypass_events: got rise=%h fall=%h, want 80 80", io.rise_evt, io.fall_evt);
    end
    io.bypass = 1'b0;
  endtask

  task automatic test_set_wins();
    do_reset();
    io.pad_in = 8'h04;
    repeat (5) tick();
    io.evt_clr = 8'h04;
    tick();
    io.evt_clr = 8'h00;
    tests++;
    if (io.rise_evt !== 8'h04 || io.gpio_clean !== 8'h04) begin
      fails++;
      $display("FAIL set_wins: got rise=%h clean=%h, want 04 04", io.rise_evt, io.gpio_clean);
    end
    io.evt_clr = 8'h04;
    tick();
    io.evt_clr = 8'h00;
    tests++;
    if (io.rise_evt !== 8'h00) begin
      fails++;
      $display("FAIL clear_after_set: got rise=%h, want 00", io.rise_evt);
    end
  endtask

  task automatic test_reset_mid_count();
    do_reset();
    io.pad_in = 8'h01;
    repeat (4) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    tests++;
    if (io.gpio_clean !== 8'h00 || io.rise_evt !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset: got clean=%h rise=%h, want 00 00", io.gpio_clean, io.rise_evt);
    end
    repeat (5) tick();
    tests++;
    if (io.gpio_clean !== 8'h00) begin
      fails++;
      $display("FAIL mid_reset_early: got clean=%h, want 00", io.gpio_clean);
    end
    tick();
    tests++;
    if (io.gpio_clean !== 8'h01 || io.rise_evt !== 8'h01) begin
      fails++;
      $display("FAIL mid_reset_update: got clean=%h rise=%h, want 01 01", io.gpio_clean, io.rise_evt);
    end
  endtask

  initial begin
    test_reset();
    test_rise_latency();
    test_glitch();
    test_fall_and_clear();
    test_bypass();
    test_set_wins();
    test_reset_mid_count();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule

// File: doc/gpio_in_conditioner.md
# gpio_in_conditioner

Input-conditioning stage that sits directly upstream of the GPIO slave's input ports. It takes raw, asynchronous pad signals and synchronizes them into `clk` with a two-flop chain. It then debounces each bit independently and drives the cleaned vector into one GPIO input port. It also latches sticky per-bit rising/falling edge events and raises a level interrupt for software polling or interrupt handling. One instance is used per input port (A–D).

## Interface
Parameters:
- `GPIO_WIDTH`, 8: number of pad bits; matches the GPIO slave port width.
- `DEBOUNCE_CYCLES`, 4: consecutive stable synchronized cycles required to accept a new level; legal range 1–255.

Ports:
- `clk`  in  1  the single clock; all state updates on its rising edge.
- `rst`  in  1  synchronous, active-high reset.
- `pad_in`  in  GPIO_WIDTH  raw asynchronous pad levels.
- `bypass`  in  1  1 = skip debounce; the synchronized level passes straight to `gpio_clean`.
- `evt_clr`  in  GPIO_WIDTH  per-bit write-1-to-clear for `rise_evt` and `fall_evt`.
- `gpio_clean`  out  GPIO_WIDTH  debounced level; connects to `GPIO_in_portX`.
- `rise_evt`  out  GPIO_WIDTH  sticky flag: `gpio_clean` bit went 0→1.
- `fall_evt`  out  GPIO_WIDTH  sticky flag: `gpio_clean` bit went 1→0.
- `irq`  out  1  OR-reduction of all `rise_evt` and `fall_evt` bits; combinational from the flag registers.

## Operation
Reset behaviour:
- `rst`=1 at a clock edge clears `sync1`, `sync2`, all counters, `gpio_clean`, `rise_evt` and `fall_evt` to 0.
- Consequently `irq` = 0 after reset.

Synchronizer:
- Per bit, `sync1 <= pad_in` and `sync2 <= sync1`.
- Only `sync2` is used downstream.

Per-bit debounce (independent counter `cnt[i]`, width `$clog2(DEBOUNCE_CYCLES+1)`):
- If `sync2[i] == gpio_clean[i]`: `cnt[i] <= 0`. This covers glitches: any return to the current level restarts the count.
- Otherwise, if `cnt[i] == DEBOUNCE_CYCLES-1`: `gpio_clean[i] <= sync2[i]` and `cnt[i] <= 0`. Call this the "update" condition.
- Otherwise: `cnt[i] <= cnt[i] + 1`.
- The counter never exceeds `DEBOUNCE_CYCLES-1`, so no wrap-around is possible.

Bypass mode:
- While `bypass`=1: `gpio_clean <= sync2` every cycle and all `cnt <= 0`.
- An update occurs on any bit where `sync2` differs from `gpio_clean`.
- Toggling `bypass` mid-count discards the partial count.

Edge events (evaluated in the same cycle as an update):
- Rising update (new level 1) sets `rise_evt[i]`.
- Falling update (new level 0) sets `fall_evt[i]`.
- `evt_clr[i]`=1 clears both `rise_evt[i]` and `fall_evt[i]`.
- If set and clear occur in the same cycle on the same bit, set wins.
- Flags never clear without `evt_clr` or `rst`.

## Timing
Latency, for a pad change that is stable before edge k:
- `sync2` reflects it after edge k+1.
- Debounce mode: `gpio_clean` and the event flag update after edge k+1+DEBOUNCE_CYCLES.
- Bypass mode: update after edge k+2.
- `DEBOUNCE_CYCLES`=1 therefore gives the same latency as bypass.
- `irq` follows the flags with no extra cycle.

Glitch rejection:
- A `sync2` excursion shorter than `DEBOUNCE_CYCLES` cycles produces no change in `gpio_clean` and no event.

Boundary conditions:
- Pad held at 1 through and after reset: after release, `gpio_clean` rises after 2+DEBOUNCE_CYCLES edges and `rise_evt` sets. Software clears this spurious event.
- Reset asserted mid-count: count is lost and outputs return to 0 on that edge.
- Multiple bits changing together update independently, each on its own count.

## Test plan
- Reset, then `pad_in`=8'h01 held from edge 1 (D=4) → `gpio_clean[0]`=1, `rise_evt`=8'h01 and `irq`=1 after edge 6; nothing earlier.
- `gpio_clean`=0, pulse `pad_in[3]` high for 3 cycles (D=4) → `gpio_clean`, `rise_evt` and `fall_evt` stay 8'h00.
- With `gpio_clean`=8'hFF, drop `pad_in` to 8'h0F → `gpio_clean`=8'h0F after 2+D edges and `fall_evt`=8'hF0; then `evt_clr`=8'hF0 for one cycle → flags 8'h00 and `irq`=0.
- `bypass`=1, toggle `pad_in[7]` every 4 cycles → `gpio_clean[7]` follows with exactly 2-edge latency, and `rise_evt[7]`/`fall_evt[7]` both set.
- Assert `evt_clr[2]`=1 on the same edge a rising update sets `rise_evt[2]` → `rise_evt[2]`=1 (set wins).
- Assert `rst` for one edge while `cnt`=2, then release with the pad unchanged → counting restarts from zero and `gpio_clean` updates 2+D edges after release.
